// File: rtl/uart_rx_capture.sv
// uart_rx_capture: UART receive front end.
// Synchronizes the serial line, deframes 8-bit characters (optional even
// parity), and buffers them in a small FIFO with a valid/ready output.
//
// Ports:
//   clk          clock
//   rst          asynchronous, active-high reset
//   rx_i         serial line, idle high
//   rx_en_i      receiver enable; low aborts any frame in progress
//   data_o       FIFO head byte, meaningful only while valid_o=1
//   valid_o      FIFO non-empty
//   ready_i      consumer pop, taken when valid_o & ready_i
//   level_o      FIFO occupancy, 0..FIFO_DEPTH
//   frame_err_o  1-cycle pulse, stop bit sampled low (byte dropped)
//   parity_err_o 1-cycle pulse, parity mismatch (byte dropped)
//   overflow_o   1-cycle pulse, byte dropped because FIFO full
//
// state  | meaning
// IDLE   | waiting for a falling edge on the synced line
// START  | timing to the middle of the start bit
// DATA   | sampling 8 data bits, LSB first
// PARITY | sampling the even-parity bit (PARITY_EN only)
// STOP   | sampling the stop bit, then push or report an error
module uart_rx_capture #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx_i,
  input  logic                        rx_en_i,
  output logic [7:0]                  data_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [$clog2(FIFO_DEPTH):0] level_o,
  output logic                        frame_err_o,
  output logic                        parity_err_o,
  output logic                        overflow_o
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_LOAD  = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // Line synchronizer; rx_d is one cycle behind rx_s for edge detection.
  logic rx_meta, rx_s, rx_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic          par_bad, par_bad_n;
  logic          push, frame_err_n, parity_err_n;
  logic          tc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      timer        <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      par_bad      <= 1'b0;
      frame_err_o  <= 1'b0;
      parity_err_o <= 1'b0;
    end else begin
      state        <= state_n;
      timer        <= timer_n;
      bit_cnt      <= bit_cnt_n;
      shift        <= shift_n;
      par_bad      <= par_bad_n;
      frame_err_o  <= frame_err_n;
      parity_err_o <= parity_err_n;
    end
  end

  // Timer is a down-counter; every sample point is its terminal count.
  assign tc = (timer == '0);

  always_comb begin
    state_n      = state;
    timer_n      = tc ? timer : timer - TW'(1);
    bit_cnt_n    = bit_cnt;
    shift_n      = shift;
    par_bad_n    = par_bad;
    push         = 1'b0;
    frame_err_n  = 1'b0;
    parity_err_n = 1'b0;
    if (state != IDLE && !rx_en_i) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (rx_en_i && rx_d && !rx_s) begin
            state_n   = START;
            timer_n   = HALF_LOAD;
            bit_cnt_n = '0;
            par_bad_n = 1'b0;
          end
        end
        START: begin
          if (tc) begin
            if (rx_s) begin
              state_n = IDLE;
            end else begin
              state_n = DATA;
              timer_n = BIT_LOAD;
            end
          end
        end
        DATA: begin
          if (tc) begin
            shift_n = {rx_s, shift[7:1]};
            timer_n = BIT_LOAD;
            if (bit_cnt == 3'd7) begin
              state_n = PARITY_EN ? PARITY : STOP;
            end else begin
              bit_cnt_n = bit_cnt + 3'd1;
            end
          end
        end
        PARITY: begin
          if (tc) begin
            par_bad_n = ^{shift, rx_s};
            state_n   = STOP;
            timer_n   = BIT_LOAD;
          end
        end
        STOP: begin
          if (tc) begin
            state_n = IDLE;
            // Framing error wins over parity; at most one pulse per frame.
            if (!rx_s) begin
              frame_err_n = 1'b1;
            end else if (par_bad) begin
              parity_err_n = 1'b1;
            end else begin
              push = 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Byte FIFO.
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          pop, full, do_push;

  assign valid_o = (level_o != '0);
  assign full    = (level_o == LW'(FIFO_DEPTH));
  assign pop     = valid_o & ready_i;
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign do_push = push & (~full | pop);
  assign data_o  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_o    <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      level_o    <= level_o + LW'(do_push) - LW'(pop);
      overflow_o <= push & full & ~pop;
    end
  end

endmodule

// File: tb/tb_uart_rx_capture.sv
// Bench for uart_rx_capture: one instance without parity (a), one with
// even parity (b). Frames are generated bit by bit from the UART format and
// expected bytes are kept in a queue; error pulses are tallied and compared
// against expected tallies.
module tb_uart_rx_capture;
  localparam int CPB   = 16;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_en = 1'b1;
  logic       rx_a = 1'b1, rx_b = 1'b1;
  logic       ready_a = 1'b0, ready_b = 1'b0;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic [3:0] level_a, level_b;
  logic       fe_a, pe_a, ov_a, fe_b, pe_b, ov_b;

  int checks = 0;
  int errors = 0;
  int n_fe_a = 0, n_pe_a = 0, n_ov_a = 0, n_fe_b = 0, n_pe_b = 0, n_ov_b = 0;
  int x_fe_a = 0, x_pe_a = 0, x_ov_a = 0, x_fe_b = 0, x_pe_b = 0, x_ov_b = 0;
  logic [7:0] q[$];
  bit sel_p = 1'b0;

  uart_rx_capture #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY_EN(1'b0)) dut_a (
    .clk(clk), .rst(rst), .rx_i(rx_a), .rx_en_i(rx_en), .data_o(data_a),
    .valid_o(valid_a), .ready_i(ready_a), .level_o(level_a),
    .frame_err_o(fe_a), .parity_err_o(pe_a), .overflow_o(ov_a));

  uart_rx_capture #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY_EN(1'b1)) dut_b (
    .clk(clk), .rst(rst), .rx_i(rx_b), .rx_en_i(rx_en), .data_o(data_b),
    .valid_o(valid_b), .ready_i(ready_b), .level_o(level_b),
    .frame_err_o(fe_b), .parity_err_o(pe_b), .overflow_o(ov_b));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fe_a) n_fe_a++;
    if (pe_a) n_pe_a++;
    if (ov_a) n_ov_a++;
    if (fe_b) n_fe_b++;
    if (pe_b) n_pe_b++;
    if (ov_b) n_ov_b++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_pulses(input string tag);
    check({tag, "_fe_a"}, n_fe_a, x_fe_a);
    check({tag, "_pe_a"}, n_pe_a, x_pe_a);
    check({tag, "_ov_a"}, n_ov_a, x_ov_a);
    check({tag, "_fe_b"}, n_fe_b, x_fe_b);
    check({tag, "_pe_b"}, n_pe_b, x_pe_b);
    check({tag, "_ov_b"}, n_ov_b, x_ov_b);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame on the selected line, one loop pass per clock.
  // rise: first clock (counted from the start-bit drive) at which valid was seen.
  // pop_at: clock during which ready_a is held high for one cycle.
  // en_off_at: clock at which rx_en drops for the rest of the frame.
  task automatic send(input logic [7:0] b, input bit use_par, input bit par,
                      input bit stop, input bit tail, input int pop_at,
                      input int en_off_at, output int rise, output logic [7:0] popped);
    logic [10:0] bits;
    logic        lv, v;
    int          nb;
    nb     = use_par ? 11 : 10;
    bits   = use_par ? {stop, par, b, 1'b0} : {1'b0, stop, b, 1'b0};
    rise   = -1;
    popped = 8'h00;
    for (int c = 0; c < nb * CPB + 12; c++) begin
      lv = (c < nb * CPB) ? bits[c / CPB] : tail;
      if (sel_p) rx_b = lv; else rx_a = lv;
      if (c == en_off_at) rx_en = 1'b0;
      @(posedge clk);
      #1;
      v = sel_p ? valid_b : valid_a;
      if (v && rise < 0) rise = c + 1;
      if (c + 1 == pop_at) begin
        popped  = data_a;
        ready_a = 1'b1;
      end else if (c == pop_at) begin
        ready_a = 1'b0;
      end
    end
    rx_en = 1'b1;
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] exp_b;
    exp_b = q.pop_front();
    check({tag, "_valid"}, sel_p ? valid_b : valid_a, 1);
    check({tag, "_data"}, sel_p ? data_b : data_a, exp_b);
    if (sel_p) ready_b = 1'b1; else ready_a = 1'b1;
    tick(1);
    ready_a = 1'b0;
    ready_b = 1'b0;
    check({tag, "_level"}, sel_p ? level_b : level_a, q.size());
  endtask

  initial begin
    int         rise;
    logic [7:0] b, popped;

    // Reset state.
    tick(3);
    check("rst_valid_a", valid_a, 0);
    check("rst_level_a", level_a, 0);
    check("rst_valid_b", valid_b, 0);
    check("rst_level_b", level_b, 0);
    rst = 1'b0;
    tick(2);
    check_pulses("rst");

    // 0xA5 8N1: valid appears one clock after the stop sample.
    // Start edge reaches rx_s after 2 clocks, stop sample is half a bit
    // plus 9 bits later: 2 + 8 + 144 = 154, valid at 155.
    sel_p = 1'b0;
    q.push_back(8'hA5);
    send(8'hA5, 0, 0, 1, 1, -1, -1, rise, popped);
    check("a5_rise", rise, 155);
    check("a5_level", level_a, 1);
    pop_check("a5");
    check_pulses("a5");

    // Random bytes.
    repeat (6) begin
      b = 8'($urandom_range(0, 255));
      q.push_back(b);
      send(b, 0, 0, 1, 1, -1, -1, rise, popped);
      check("rnd_rise", rise, 155);
      pop_check("rnd");
    end

    // False start: short low glitch.
    rx_a = 1'b0;
    tick(4);
    rx_a = 1'b1;
    tick(40);
    check("glitch_level", level_a, 0);
    check_pulses("glitch");
    b = 8'($urandom_range(0, 255));
    q.push_back(b);
    send(b, 0, 0, 1, 1, -1, -1, rise, popped);
    check("after_glitch_rise", rise, 155);
    pop_check("after_glitch");

    // Framing error, line then held low; only one frame error.
    send(8'h3C, 0, 0, 0, 0, -1, -1, rise, popped);
    x_fe_a++;
    check("ferr_level", level_a, 0);
    tick(40);
    rx_a = 1'b1;
    tick(20);
    check_pulses("ferr");
    q.push_back(8'h55);
    send(8'h55, 0, 0, 1, 1, -1, -1, rise, popped);
    check("x55_rise", rise, 155);
    pop_check("x55");
    check_pulses("x55");

    // Fill to full, ninth byte overflows.
    for (int i = 1; i <= 8; i++) begin
      q.push_back(8'(i));
      send(8'(i), 0, 0, 1, 1, -1, -1, rise, popped);
    end
    check("full_level", level_a, DEPTH);
    check_pulses("full");
    send(8'h09, 0, 0, 1, 1, -1, -1, rise, popped);
    x_ov_a++;
    check("ovf_level", level_a, DEPTH);
    check_pulses("ovf");
    for (int i = 0; i < DEPTH; i++) pop_check("drain1");

    // Refill, then push and pop in the same cycle at full.
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom_range(0, 255));
      q.push_back(b);
      send(b, 0, 0, 1, 1, -1, -1, rise, popped);
    end
    b = 8'($urandom_range(0, 255));
    send(b, 0, 0, 1, 1, 154, -1, rise, popped);
    check("pp_popped", popped, q.pop_front());
    q.push_back(b);
    check("pp_level", level_a, DEPTH);
    check_pulses("pp");
    for (int i = 0; i < DEPTH; i++) pop_check("drain2");

    // Parity instance.
    sel_p = 1'b1;
    send(8'h0F, 1, 1, 1, 1, -1, -1, rise, popped);
    x_pe_b++;
    check("perr_level", level_b, 0);
    check_pulses("perr");
    q.push_back(8'h0F);
    send(8'h0F, 1, 0, 1, 1, -1, -1, rise, popped);
    check("par_rise", rise, 171);
    pop_check("par_ok");
    repeat (4) begin
      b = 8'($urandom_range(0, 255));
      q.push_back(b);
      send(b, 1, ^b, 1, 1, -1, -1, rise, popped);
      pop_check("par_rnd");
    end
    b = 8'($urandom_range(0, 255));
    send(b, 1, ~(^b), 0, 1, -1, -1, rise, popped);
    x_fe_b++;
    check("prec_level", level_b, 0);
    check_pulses("prec");

    // Enable dropped during data bit 3.
    sel_p = 1'b0;
    b = 8'($urandom_range(0, 255));
    send(b, 0, 0, 1, 1, -1, 4 * CPB + 8, rise, popped);
    check("abort_level", level_a, 0);
    check_pulses("abort");
    b = 8'($urandom_range(0, 255));
    q.push_back(b);
    send(b, 0, 0, 1, 1, -1, -1, rise, popped);
    pop_check("after_abort");

    // Reset with three bytes buffered and a frame in flight.
    repeat (3) begin
      b = 8'($urandom_range(0, 255));
      q.push_back(b);
      send(b, 0, 0, 1, 1, -1, -1, rise, popped);
    end
    check("pre_rst_level", level_a, 3);
    rx_a = 1'b0;
    tick(30);
    rst = 1'b1;
    #1;
    check("mid_rst_level", level_a, 0);
    check("mid_rst_valid", valid_a, 0);
    q.delete();
    tick(2);
    rx_a = 1'b1;
    rst  = 1'b0;
    tick(20);
    check("post_rst_level", level_a, 0);
    check_pulses("post_rst");
    q.push_back(8'h7E);
    send(8'h7E, 0, 0, 1, 1, -1, -1, rise, popped);
    check("x7e_rise", rise, 155);
    pop_check("x7e");
    check_pulses("end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_capture.md
Name: uart_rx_capture

Overview:
- Synthesizable UART receive front end. Samples the serial line driven by the SoC UART TX pin.
- Deframes 8-bit characters and buffers them in a small FIFO with a valid/ready output, so a consumer can take whole bytes instead of bit timing.
- Error conditions are reported as single-cycle pulses.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit. Must be ≥4. Default matches 3125000 baud at 50 MHz.
- FIFO_DEPTH, 8, byte entries. Power of two, ≥2.
- PARITY_EN, 0, 1 = one even-parity bit follows the data bits.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- rx_i  in  1  serial line, idle high
- rx_en_i  in  1  receiver enable
- data_o  out  8  FIFO head byte; valid only when valid_o=1
- valid_o  out  1  FIFO non-empty
- ready_i  in  1  consumer pop; a pop occurs on valid_o & ready_i
- level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- frame_err_o  out  1  1-cycle pulse, stop bit sampled 0
- parity_err_o  out  1  1-cycle pulse, parity mismatch
- overflow_o  out  1  1-cycle pulse, byte dropped because FIFO full

Behaviour:
- Reset, asynchronous and active-high, clears:
  - synchronizer flops to 1
  - FSM to IDLE
  - FIFO pointers and level_o to 0
  - valid_o and all error pulses to 0
- data_o is don't-care while valid_o=0.
- rx_i passes through a 2-flop synchronizer, rx_s, plus a delayed copy rx_d. All timing below is in synced-domain cycles.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: go to START when rx_en_i=1 & rx_d=1 & rx_s=0 (falling edge). Call this cycle t. Clear the bit counter.
  - START: at t+CLKS_PER_BIT/2, sample rx_s. If 1 (false start), return to IDLE with no error. If 0, go to DATA.
  - DATA: sample bit i (i=0..7, LSB first) at t+CLKS_PER_BIT/2+(i+1)·CLKS_PER_BIT. After bit 7, go to PARITY if PARITY_EN, else STOP.
  - PARITY: sample one bit period later. Mismatch means XOR(data,parity)≠0.
  - STOP: sample one bit period later.
    - If the stop bit is 0: pulse frame_err_o and drop the byte.
    - Else if parity failed: pulse parity_err_o and drop the byte.
    - Else push the byte.
    - Frame error takes precedence over parity error. Only one error pulse per frame.
  - After the STOP sample, return to IDLE in the next cycle. A new start needs a fresh falling edge, so a line stuck low after a framing error is ignored until it goes high.
- rx_en_i=0 in any non-IDLE state forces IDLE on the next edge. The partial frame is discarded with no error pulse. FIFO contents are unaffected.
- FIFO:
  - A push written in cycle c makes valid_o=1 and shows the byte on data_o in cycle c+1. Latency is 1 clock after the STOP sample edge.
  - Push while full with no pop in the same cycle: byte dropped, overflow_o pulses, contents unchanged.
  - Push and pop in the same cycle while full: both take effect, no overflow, level unchanged.
  - Push and pop in the same cycle at level 1: head advances, level stays 1.
  - Pop while empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH. level_o spans 0..FIFO_DEPTH.
- Reset asserted mid-frame or with a non-empty FIFO: everything clears immediately. No pulses are generated.

Test Plan:
- Default parameters, ready_i=1 after valid. Send 0xA5 8N1 → valid_o rises 1 cycle after the stop sample, data_o=0xA5, level_o=1. Pop returns level_o to 0. No error pulses.
- Drive rx_i low for 4 cycles, then high → no byte, no error pulse, FSM back in IDLE.
- Send 0x3C with stop bit=0 → one frame_err_o pulse, level_o stays 0. Hold the line low for 40 cycles, then send 0x55 correctly → 0x55 received, no extra frame start.
- ready_i=0, send 9 bytes 0x01..0x09 → level_o=8 after the 8th, overflow_o pulses once on the 9th. Drain → bytes 0x01..0x08 in order. Then a push and pop in the same cycle at full → level_o stays 8, no overflow.
- PARITY_EN=1, send 0x0F with parity bit 1 → parity_err_o pulse, no push. Send 0x0F with parity bit 0 → 0x0F received.
- Mid-frame, deassert rx_en_i at bit 3 → no byte, no error. Separately, assert rst with level_o=3 → level_o=0, valid_o=0, and the next 0x7E is received cleanly.
